debug_trace_buffer: RTL



---
 rtl/debug_trace_buffer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/debug_trace_buffer.sv
// Circular trace buffer for pipeline stage-latch snapshots with post-trigger stop and word readout.
// Optional TRACE_TIMESTAMP_EN stores a 32-bit free-running cycle count in the top of each entry.
module debug_trace_buffer #(
    parameter int unsigned NB_SNAPSHOT  = 96,
    parameter int unsigned N_CHANNELS   = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned POST_TRIGGER = 4,
    parameter int unsigned NB_WORD      = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [N_CHANNELS*NB_SNAPSHOT-1:0]   i_snapshot,
    input  logic                                i_valid,
    input  logic                                i_arm,
    input  logic                                i_trigger,
    input  logic                                i_rd_req,
    output logic [NB_WORD-1:0]                  o_rd_data,
    output logic                                o_rd_valid,
    output logic [2:0]                          o_state,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic                                o_triggered,
    output logic                                o_done
);

    localparam int unsigned NB_CAPTURE = N_CHANNELS * NB_SNAPSHOT;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned NB_ENTRY = NB_CAPTURE + 32;
`else
    localparam int unsigned NB_ENTRY = NB_CAPTURE;
`endif
    localparam int unsigned N_WORDS = (NB_ENTRY + NB_WORD - 1) / NB_WORD;
    localparam int unsigned NB_PTR  = $clog2(DEPTH);
    localparam int unsigned NB_CNT  = NB_PTR + 1;
    localparam int unsigned NB_WIDX = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StPost  = 3'd2,
        StDone  = 3'd3,
        StRead  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [NB_PTR-1:0]       r_wr_ptr;
    logic [NB_PTR-1:0]       r_rd_ptr;
    logic [NB_CNT-1:0]       r_count;
    logic [NB_CNT-1:0]       r_rd_idx;
    logic [NB_WIDX-1:0]      r_word;
    logic [NB_PTR-1:0]       r_post_cnt;
    logic [NB_WORD-1:0]      r_rd_data;
    logic                    r_rd_valid;
    logic [NB_ENTRY-1:0]     r_mem [DEPTH];

    logic [NB_ENTRY-1:0]     w_entry_in;
    logic                    w_capture;
    logic [NB_PTR-1:0]       w_oldest;
    logic [NB_PTR-1:0]       w_ptr;
    logic [NB_WIDX-1:0]      w_word;
    logic [NB_CNT-1:0]       w_idx;
    logic [N_WORDS*NB_WORD-1:0] w_entry_pad;
    logic [NB_WORD-1:0]      w_rd_word;
    logic                    w_last_word;
    logic                    w_last_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] r_timestamp;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_timestamp <= '0;
        else       r_timestamp <= r_timestamp + 32'd1;
    end

    assign w_entry_in = {r_timestamp, i_snapshot};
`else
    assign w_entry_in = i_snapshot;
`endif

    assign w_capture = !i_arm && i_valid && (r_state == StArmed || r_state == StPost);
    // count can equal DEPTH; its low bits then wrap to wr_ptr, which is the oldest slot
    assign w_oldest  = r_wr_ptr - r_count[NB_PTR-1:0];

    always_ff @(posedge i_clk) begin
        if (w_capture) r_mem[r_wr_ptr] <= w_entry_in;
    end

    // DONE starts a fresh walk from the oldest entry; READ continues the saved one
    always_comb begin
        w_ptr  = r_rd_ptr;
        w_word = r_word;
        w_idx  = r_rd_idx;
        if (r_state == StDone) begin
            w_ptr  = w_oldest;
            w_word = '0;
            w_idx  = '0;
        end
        w_entry_pad                 = '0;
        w_entry_pad[NB_ENTRY-1:0]   = r_mem[w_ptr];
        w_rd_word    = w_entry_pad[32'(w_word)*NB_WORD +: NB_WORD];
        w_last_word  = (w_word == NB_WIDX'(N_WORDS - 1));
        w_last_entry = (w_idx == r_count - 1'b1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_idx   <= '0;
            r_word     <= '0;
            r_post_cnt <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (i_arm) begin
                r_state  <= StArmed;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                unique case (r_state)
                    StIdle: ;
                    StArmed, StPost: begin
                        if (i_valid) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_count != NB_CNT'(DEPTH)) r_count <= r_count + 1'b1;
                        end
                        if (r_state == StArmed) begin
                            if (i_trigger) begin
                                if (POST_TRIGGER == 0) begin
                                    r_state <= StDone;
                                end else begin
                                    r_state    <= StPost;
                                    r_post_cnt <= NB_PTR'(POST_TRIGGER);
                                end
                            end
                        end else if (i_valid) begin
                            r_post_cnt <= r_post_cnt - 1'b1;
                            if (r_post_cnt == NB_PTR'(1)) r_state <= StDone;
                        end
                    end
                    StDone, StRead: begin
                        if (i_rd_req) begin
                            if (r_count == '0) begin
                                r_state <= StIdle;
                            end else begin
                                r_rd_valid <= 1'b1;
                                r_rd_data  <= w_rd_word;
                                r_state    <= StRead;
                                if (w_last_word) begin
                                    r_word <= '0;
                                    if (w_last_entry) begin
                                        r_state <= StIdle;
                                        r_count <= '0;
                                    end else begin
                                        r_rd_ptr <= w_ptr + 1'b1;
                                        r_rd_idx <= w_idx + 1'b1;
                                    end
                                end else begin
                                    r_word   <= w_word + 1'b1;
                                    r_rd_ptr <= w_ptr;
                                    r_rd_idx <= w_idx;
                                end
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_state     = r_state;
    assign o_count     = r_count;
    assign o_triggered = (r_state == StPost) || (r_state == StDone) || (r_state == StRead);
    assign o_done      = (r_state == StDone) || (r_state == StRead);

endmodule
